systolic_load_ctrl: RTL and testbench

//  Sequencer for the A-operand staging memory (DIM skewed transpose FIFOs) of
//  the DIM x DIM systolic matrix array. Accepts DIM rows over a valid/ready

---
 rtl/systolic_load_ctrl.sv | 111 +++++++++++
 tb/tb_systolic_load_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_load_ctrl.sv
// Load/compute sequencer for the systolic array A-operand staging memory.
// Accepts DIM rows, writes them by index, then drives shift enable to feed and drain.
module systolic_load_ctrl #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [BITS_AB*DIM-1:0]   in_data,
    output logic                     in_ready,
    output logic                     a_wren,
    output logic [$clog2(DIM)-1:0]   a_row,
    output logic [BITS_AB*DIM-1:0]   a_din,
    output logic                     mem_en,
    output logic                     feeding,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(2*DIM);
    localparam int RW = $clog2(DIM);

    localparam logic [CW-1:0] ROW_LAST    = CW'(DIM - 1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(2*DIM - 2);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DIM - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   row_cnt;
    logic [CW-1:0]   cyc_cnt;
    logic            accept;

    // Abort and reset both suppress the write in the cycle they are seen.
    assign accept = in_ready & in_valid & ~abort & ~rst;
    assign a_wren = accept;
    assign a_row  = row_cnt[RW-1:0];
    assign a_din  = accept ? in_data : '0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start && !abort) nxt = LOAD;
            LOAD: begin
                if (abort)
                    nxt = IDLE;
                else if (accept && row_cnt == ROW_LAST)
                    nxt = STREAM;
            end
            STREAM: begin
                if (abort)
                    nxt = IDLE;
                else if (cyc_cnt == STREAM_LAST)
                    nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)
                    nxt = IDLE;
                else if (cyc_cnt == DRAIN_LAST)
                    nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row_cnt  <= '0;
            cyc_cnt  <= '0;
            in_ready <= 1'b0;
            mem_en   <= 1'b0;
            feeding  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= nxt;

            if (nxt != LOAD)
                row_cnt <= '0;
            else if (accept)
                row_cnt <= row_cnt + 1'b1;

            if (nxt != state)
                cyc_cnt <= '0;
            else if (state == STREAM || state == DRAIN)
                cyc_cnt <= cyc_cnt + 1'b1;
            else
                cyc_cnt <= '0;

            in_ready <= (nxt == LOAD);
            mem_en   <= (nxt == STREAM) || (nxt == DRAIN);
            feeding  <= (nxt == STREAM);
            busy     <= (nxt != IDLE);
            done     <= (nxt == DONE);
        end
    end

endmodule

// File: tb/tb_systolic_load_ctrl.sv
// Self-checking bench for systolic_load_ctrl: directed passes plus random traffic
// checked cycle by cycle against a timeline model of one load/compute pass.
module tb_systolic_load_ctrl;

    localparam int BITS_AB = 8;
    localparam int DIM     = 8;
    localparam int W       = BITS_AB * DIM;
    localparam int RW      = $clog2(DIM);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_ready;
    logic            a_wren;
    logic [RW-1:0]   a_row;
    logic [W-1:0]    a_din;
    logic            mem_en;
    logic            feeding;
    logic            busy;
    logic            done;

    systolic_load_ctrl #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .a_wren   (a_wren),
        .a_row    (a_row),
        .a_din    (a_din),
        .mem_en   (mem_en),
        .feeding  (feeding),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model: a pass is idle, loading rows, or a fixed timeline after the last row.
    bit m_busy    = 0;
    bit m_loading = 0;
    int m_rows    = 0;
    int m_t_last  = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit s, input bit a, input bit v, input bit r);
        int ph;
        int k;
        bit e_wren;
        @(posedge clk);
        #2;
        start    = s;
        abort    = a;
        in_valid = v;
        rst      = r;
        in_data  = {$urandom, $urandom};
        #2;
        // 0 idle, 1 load, 2 stream, 3 drain, 4 done
        if (!m_busy) ph = 0;
        else if (m_loading) ph = 1;
        else begin
            k = cyc - m_t_last;
            if (k <= 2*DIM - 1)      ph = 2;
            else if (k <= 3*DIM - 2) ph = 3;
            else                     ph = 4;
        end
        e_wren = (ph == 1) && v && !a && !r;
        chk("in_ready", W'(in_ready), W'(ph == 1));
        chk("a_wren",   W'(a_wren),   W'(e_wren));
        chk("a_row",    W'(a_row),    W'((ph == 1) ? m_rows : 0));
        chk("a_din",    a_din,        e_wren ? in_data : '0);
        chk("mem_en",   W'(mem_en),   W'(ph == 2 || ph == 3));
        chk("feeding",  W'(feeding),  W'(ph == 2));
        chk("busy",     W'(busy),     W'(ph != 0));
        chk("done",     W'(done),     W'(ph == 4));
        chk("wren_and_mem", W'(a_wren & mem_en), '0);
        chk("row_range", W'(a_wren && (int'(a_row) >= DIM)), '0);
        // advance the model across the coming clock edge
        if (r) begin
            m_busy = 0; m_loading = 0; m_rows = 0;
        end else begin
            case (ph)
                0: if (s && !a) begin m_busy = 1; m_loading = 1; m_rows = 0; end
                1: begin
                    if (a) begin m_busy = 0; m_loading = 0; m_rows = 0; end
                    else if (e_wren) begin
                        m_rows++;
                        if (m_rows == DIM) begin
                            m_loading = 0; m_rows = 0; m_t_last = cyc;
                        end
                    end
                end
                2, 3: if (a) m_busy = 0;
                default: m_busy = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic run_full();
        int nmem = 0, nfeed = 0, nwr = 0, dat = -1;
        step(1, 0, 1, 0);
        for (int i = 1; i <= 4*DIM + 1; i++) begin
            step(0, 0, 1, 0);
            if (mem_en)  nmem++;
            if (feeding) nfeed++;
            if (a_wren) begin
                chk("row_order", W'(a_row), W'(nwr));
                nwr++;
            end
            if (done) dat = i;
        end
        chk("pass_writes",  W'(nwr),   W'(DIM));
        chk("pass_mem_en",  W'(nmem),  W'(3*DIM - 2));
        chk("pass_feeding", W'(nfeed), W'(2*DIM - 1));
        chk("pass_done_at", W'(dat),   W'(4*DIM - 1));
    endtask

    initial begin
        int wr8, first_mem, nwr;
        rst = 1; start = 1; abort = 0; in_valid = 1; in_data = '0;
        @(posedge clk);

        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        step(0, 0, 0, 0);

        run_full();

        // LOAD with a gappy source
        wr8 = -1; first_mem = -1; nwr = 0;
        step(1, 0, 0, 0);
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, (i % 2) == 1, 0);
            if (a_wren) begin nwr++; if (nwr == DIM) wr8 = i; end
            if (mem_en && first_mem < 0) first_mem = i;
        end
        chk("gappy_stream_start", W'(first_mem - wr8), W'(1));

        // abort on the third STREAM cycle
        step(1, 0, 1, 0);
        for (int i = 1; i <= DIM + 2; i++) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("abort_cycle_mem_en", W'(mem_en), W'(1));
        step(0, 0, 1, 0);
        chk("after_abort_mem_en", W'(mem_en), '0);
        chk("after_abort_busy",   W'(busy),   '0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        run_full();

        // start held high throughout a pass, then abort+start in IDLE
        for (int i = 0; i < 4*DIM; i++) step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("abort_start_idle", W'(busy), '0);

        // abort in LOAD mid-row, and reset mid-LOAD
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);

        // random traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
